// File: rtl/fir_pkg.sv
// Shared types, sizes and helpers for the FIR data-sample buffer controller.
// Word indices are 0..TAPS-1; the BRAM is byte addressed, so an index maps to index*4.
package fir_pkg;

  localparam int TAPS       = 11;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 12;
  localparam int CNT_W      = 4;
  localparam int WORD_SHIFT = 2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    ACCEPT,
    READ
  } state_e;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] idx);
    return ADDR_W'(idx) << WORD_SHIFT;
  endfunction

  function automatic logic [CNT_W-1:0] dec_mod(input logic [CNT_W-1:0] idx);
    return (idx == '0) ? LAST_IDX : idx - 1'b1;
  endfunction

endpackage

// File: rtl/fir_data_buf_ctrl_if.sv
// Bundles the control handshake, the input AXI-Stream, the data BRAM port and the MAC feed.
// The controller sits on the slave modport; the environment drives the master side.
interface fir_data_buf_ctrl_if;
  import fir_pkg::*;

  logic              ap_start;
  logic              ap_done;

  logic              ss_tvalid;
  logic [DATA_W-1:0] ss_tdata;
  logic              ss_tlast;
  logic              ss_tready;

  logic              data_EN;
  logic [3:0]        data_WE;
  logic [ADDR_W-1:0] data_A;
  logic [DATA_W-1:0] data_Di;
  logic [DATA_W-1:0] data_Do;

  logic              mac_valid;
  logic [DATA_W-1:0] mac_data;
  logic [CNT_W-1:0]  mac_idx;
  logic              mac_last;
  logic              mac_eos;

  modport slave (
    input  ap_start, ss_tvalid, ss_tdata, ss_tlast, data_Do,
    output ap_done, ss_tready, data_EN, data_WE, data_A, data_Di,
    output mac_valid, mac_data, mac_idx, mac_last, mac_eos
  );

  modport master (
    output ap_start, ss_tvalid, ss_tdata, ss_tlast, data_Do,
    input  ap_done, ss_tready, data_EN, data_WE, data_A, data_Di,
    input  mac_valid, mac_data, mac_idx, mac_last, mac_eos
  );

endinterface

// File: rtl/fir_wrap_ctr.sv
// Modulo-TAPS counter with load > inc > dec priority.
// wrap_o flags the cycle in which the requested step wraps past the end of the ring.
module fir_wrap_ctr
  import fir_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end else if (dec_i) begin
      cnt_d = dec_mod(cnt_q);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = !load_i && ((inc_i && (cnt_q == LAST_IDX)) || (dec_i && (cnt_q == '0)));

endmodule

// File: rtl/fir_data_buf_ctrl.sv
// Writes incoming samples into an 11-entry ring in the data BRAM, then reads the ring back
// newest-first so the MAC sees x[n-k] paired with tap k; the ring is zeroed at each start.
module fir_data_buf_ctrl
  import fir_pkg::*;
(
  input logic                axis_clk,
  input logic                axis_rst_n,
  fir_data_buf_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             eos_q, eos_d;
  logic             rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0] rd_tap_q, rd_tap_d;

  logic [CNT_W-1:0] wptr, rptr, clr_cnt, tap;
  logic             wptr_inc, wptr_load, rptr_dec, rptr_load;
  logic             clr_inc, clr_load, tap_inc, tap_load;
  logic             wptr_wrap, rptr_wrap, clr_wrap, tap_wrap;
  logic             unused_ptr_wraps;

  fir_wrap_ctr u_wptr (
    .clk(axis_clk), .rst_n(axis_rst_n), .inc_i(wptr_inc), .dec_i(1'b0),
    .load_i(wptr_load), .load_val_i('0), .cnt_o(wptr), .wrap_o(wptr_wrap)
  );

  fir_wrap_ctr u_rptr (
    .clk(axis_clk), .rst_n(axis_rst_n), .inc_i(1'b0), .dec_i(rptr_dec),
    .load_i(rptr_load), .load_val_i(dec_mod(wptr)), .cnt_o(rptr), .wrap_o(rptr_wrap)
  );

  fir_wrap_ctr u_clr_cnt (
    .clk(axis_clk), .rst_n(axis_rst_n), .inc_i(clr_inc), .dec_i(1'b0),
    .load_i(clr_load), .load_val_i('0), .cnt_o(clr_cnt), .wrap_o(clr_wrap)
  );

  fir_wrap_ctr u_tap (
    .clk(axis_clk), .rst_n(axis_rst_n), .inc_i(tap_inc), .dec_i(1'b0),
    .load_i(tap_load), .load_val_i(CNT_W'(1)), .cnt_o(tap), .wrap_o(tap_wrap)
  );

  // Pointer wrap is implicit in the ring arithmetic; only CLEAR and READ need their wrap flags.
  assign unused_ptr_wraps = wptr_wrap ^ rptr_wrap;

  always_comb begin
    state_d        = state_q;
    eos_d          = eos_q;
    rd_vld_d       = 1'b0;
    rd_tap_d       = '0;
    wptr_inc       = 1'b0;
    wptr_load      = 1'b0;
    rptr_dec       = 1'b0;
    rptr_load      = 1'b0;
    clr_inc        = 1'b0;
    clr_load       = 1'b0;
    tap_inc        = 1'b0;
    tap_load       = 1'b0;
    bus.ss_tready  = 1'b0;
    bus.data_EN    = 1'b0;
    bus.data_WE    = 4'h0;
    bus.data_A     = '0;
    bus.data_Di    = '0;

    unique case (state_q)
      IDLE: begin
        wptr_load = 1'b1;
        clr_load  = 1'b1;
        if (bus.ap_start) state_d = CLEAR;
      end
      CLEAR: begin
        bus.data_EN = 1'b1;
        bus.data_WE = 4'hF;
        bus.data_A  = word_addr(clr_cnt);
        clr_inc     = 1'b1;
        if (clr_wrap) state_d = ACCEPT;
      end
      ACCEPT: begin
        bus.ss_tready = 1'b1;
        if (bus.ss_tvalid) begin
          // The write also launches the tap-0 read: the BRAM returns the new word next cycle.
          bus.data_EN = 1'b1;
          bus.data_WE = 4'hF;
          bus.data_A  = word_addr(wptr);
          bus.data_Di = bus.ss_tdata;
          eos_d       = bus.ss_tlast;
          rptr_load   = 1'b1;
          tap_load    = 1'b1;
          rd_vld_d    = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        bus.data_EN = 1'b1;
        bus.data_A  = word_addr(rptr);
        rptr_dec    = 1'b1;
        tap_inc     = 1'b1;
        rd_vld_d    = 1'b1;
        rd_tap_d    = tap;
        if (tap_wrap) begin
          wptr_inc = 1'b1;
          state_d  = eos_q ? IDLE : ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q  <= IDLE;
      eos_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_tap_q <= '0;
    end else begin
      state_q  <= state_d;
      eos_q    <= eos_d;
      rd_vld_q <= rd_vld_d;
      rd_tap_q <= rd_tap_d;
    end
  end

  assign bus.mac_valid = rd_vld_q;
  assign bus.mac_data  = rd_vld_q ? bus.data_Do : '0;
  assign bus.mac_idx   = rd_tap_q;
  assign bus.mac_last  = rd_vld_q && (rd_tap_q == LAST_IDX);
  assign bus.mac_eos   = bus.mac_last && eos_q;
  assign bus.ap_done   = bus.mac_eos;

endmodule

// File: tb/tb_fir_data_buf_ctrl.sv
// Bench for fir_data_buf_ctrl: behavioural BRAM plus a "last 11 samples, newest first" model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
module tb_fir_data_buf_ctrl;
  import fir_pkg::*;

  typedef struct packed {
    logic              en;
    logic [3:0]        we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] di;
    logic              tready;
  } bram_obs_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  idx;
    logic              last;
    logic              eos;
    logic              done;
  } mac_obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic scramble;
  int   n_pass = 0;
  int   n_total = 0;

  logic [DATA_W-1:0] bram [12];
  logic [DATA_W-1:0] hist [$];
  int                n_samp;

  fir_data_buf_ctrl_if bus ();

  fir_data_buf_ctrl dut (
    .axis_clk  (clk),
    .axis_rst_n(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // 12-word BRAM with registered, write-first read port.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 12; i++) bram[i] <= $urandom;
    end else if (bus.data_EN) begin
      if (bus.data_WE == 4'hF) begin
        bram[bus.data_A[5:2]] <= bus.data_Di;
        bus.data_Do           <= bus.data_Di;
      end else begin
        bus.data_Do <= bram[bus.data_A[5:2]];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic bram_obs_t get_bram();
    return '{bus.data_EN, bus.data_WE, bus.data_A, bus.data_Di, bus.ss_tready};
  endfunction

  function automatic mac_obs_t get_mac();
    return '{bus.mac_valid, bus.mac_data, bus.mac_idx, bus.mac_last, bus.mac_eos, bus.ap_done};
  endfunction

  // Byte address of the ring slot holding x[n-k] when sample n (0-based since clear) arrives.
  function automatic logic [ADDR_W-1:0] exp_addr(input int n, input int k);
    int w;
    w = (((n - k) % TAPS) + TAPS) % TAPS;
    return ADDR_W'(w * 4);
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < TAPS; i++) hist.push_back('0);
    n_samp = 0;
  endtask

  task automatic model_push(input logic [DATA_W-1:0] s);
    hist.push_front(s);
    if (hist.size() > TAPS) void'(hist.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered while ss_tready should be high; leaves in the cycle carrying mac_last.
  task automatic run_sample(input logic [DATA_W-1:0] s, input logic last, input string name);
    bram_obs_t eb, ab;
    mac_obs_t  em, am;
    int        n;
    n = n_samp;
    model_push(s);
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = s;
    bus.ss_tlast  = last;
    #1;
    eb = '{1'b1, 4'hF, exp_addr(n, 0), s, 1'b1};
    ab = get_bram();
    n_total++;
    if (ab !== eb) $display("FAIL %s handshake: got %h want %h", name, ab, eb);
    else n_pass++;
    for (int j = 1; j <= TAPS; j++) begin
      tick();
      if (j == 1) begin
        bus.ss_tvalid = 1'b0;
        bus.ss_tdata  = $urandom;
        bus.ss_tlast  = 1'($urandom);
      end
      #1;
      if (j < TAPS) begin
        eb = '{1'b1, 4'h0, exp_addr(n, j), '0, 1'b0};
        em = '{1'b1, hist[j-1], CNT_W'(j - 1), 1'b0, 1'b0, 1'b0};
      end else begin
        eb = '{1'b0, 4'h0, '0, '0, !last};
        em = '{1'b1, hist[j-1], CNT_W'(j - 1), 1'b1, last, last};
      end
      ab = get_bram();
      am = get_mac();
      n_total++;
      if (ab !== eb) $display("FAIL %s bram cyc %0d: got %h want %h", name, j, ab, eb);
      else n_pass++;
      n_total++;
      if (am !== em) $display("FAIL %s mac cyc %0d: got %h want %h", name, j, am, em);
      else n_pass++;
    end
    n_samp++;
  endtask

  // Pulses ap_start from IDLE and waits (bounded) for ss_tready after the clear pass.
  task automatic start_run(input string name);
    int cyc;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    #1;
    cyc = 0;
    while (!bus.ss_tready && cyc < 30) begin
      tick();
      #1;
      cyc++;
    end
    n_total++;
    if (cyc !== TAPS) $display("FAIL %s clear length: got %0d cycles want %0d", name, cyc, TAPS);
    else n_pass++;
    model_clear();
  endtask

  task automatic test_reset();
    bram_obs_t ab;
    mac_obs_t  am;
    rst_n         = 1'b0;
    scramble      = 1'b1;
    bus.ap_start  = 1'b1;
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = $urandom;
    bus.ss_tlast  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      scramble = 1'b0;
      if (i == 2) begin
        rst_n         = 1'b1;
        bus.ap_start  = 1'b0;
        bus.ss_tvalid = 1'b0;
      end
      #1;
      ab = get_bram();
      am = get_mac();
      n_total++;
      if (ab !== '0) $display("FAIL reset bram cyc %0d: got %h want 0", i, ab);
      else n_pass++;
      n_total++;
      if (am !== '0) $display("FAIL reset mac cyc %0d: got %h want 0", i, am);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    bram_obs_t eb, ab;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    #1;
    for (int i = 0; i < TAPS; i++) begin
      eb = '{1'b1, 4'hF, ADDR_W'(i * 4), '0, 1'b0};
      ab = get_bram();
      n_total++;
      if (ab !== eb) $display("FAIL clear write %0d: got %h want %h", i, ab, eb);
      else n_pass++;
      tick();
      bus.ap_start = (i == 2);
      #1;
    end
    eb = '{1'b0, 4'h0, '0, '0, 1'b1};
    ab = get_bram();
    n_total++;
    if (ab !== eb) $display("FAIL clear to accept: got %h want %h", ab, eb);
    else n_pass++;
    model_clear();
  endtask

  task automatic test_first_sample();
    run_sample(32'd5, 1'b0, "first");
  endtask

  task automatic test_end_of_stream();
    bram_obs_t ab;
    mac_obs_t  am;
    run_sample($urandom, 1'b0, "eos_s1");
    run_sample($urandom, 1'b0, "eos_s2");
    run_sample($urandom, 1'b1, "eos_s3");
    bus.ss_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.ss_tdata = $urandom;
      #1;
      ab = get_bram();
      am = get_mac();
      n_total++;
      if (ab !== '0) $display("FAIL post_eos bram cyc %0d: got %h want 0", i, ab);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (am !== '0) $display("FAIL post_eos mac cyc %0d: got %h want 0", i, am);
        else n_pass++;
      end
      tick();
    end
    bus.ss_tvalid = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    int n_rand;
    start_run("wrap");
    for (int v = 1; v <= 12; v++) run_sample(DATA_W'(v), 1'b0, $sformatf("wrap_%0d", v));
    n_rand = 4 + int'($urandom_range(3));
    for (int i = 0; i < n_rand; i++)
      run_sample($urandom, (i == n_rand - 1), $sformatf("rand_%0d", i));
  endtask

  task automatic test_reset_mid_run();
    bram_obs_t eb, ab;
    mac_obs_t  em, am;
    logic [DATA_W-1:0] s;
    start_run("midrst");
    s = $urandom;
    model_push(s);
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = s;
    bus.ss_tlast  = 1'b0;
    tick();
    bus.ss_tvalid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) tick();
    #1;
    eb = '{1'b1, 4'h0, exp_addr(0, 5), '0, 1'b0};
    em = '{1'b1, hist[4], CNT_W'(4), 1'b0, 1'b0, 1'b0};
    ab = get_bram();
    am = get_mac();
    n_total++;
    if (ab !== eb) $display("FAIL midrst tap5 bram: got %h want %h", ab, eb);
    else n_pass++;
    n_total++;
    if (am !== em) $display("FAIL midrst tap5 mac: got %h want %h", am, em);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    #1;
    n_total++;
    if (bus.mac_valid !== 1'b0 || bus.data_EN !== 1'b0)
      $display("FAIL midrst drop: got valid=%b en=%b want 0 0", bus.mac_valid, bus.data_EN);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    #1;
    start_run("restart");
    run_sample(32'd7, 1'b0, "after_rst");
    run_sample($urandom, 1'b1, "after_rst_end");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_first_sample();
    test_end_of_stream();
    test_wrap();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fir_data_buf_ctrl.md
# fir_data_buf_ctrl

Upstream controller for the FIR data-sample BRAM (12-word, byte-addressed, 4-bit byte write enable, 1-cycle registered read).
- Accepts input samples on an AXI-Stream slave and writes each into an 11-entry circular buffer held in that BRAM.
- Then streams the 11 most recent samples, newest first, to the MAC stage together with the tap index.
- Also zero-fills the buffer at the start of each run.

## Interface
- TAPS, 11, filter length, equal to the circular-buffer depth.
- DATA_W, 32, sample width.
- ADDR_W, 12, BRAM byte-address width.

- axis_clk  in  1  sole clock, rising edge.
- axis_rst_n  in  1  reset, synchronous, active-low.
- ap_start  in  1  one-cycle start pulse; honoured only in IDLE.
- ap_done  out  1  one-cycle pulse after the last sample of the stream is fully read out.
- ss_tvalid  in  1  input sample valid.
- ss_tdata  in  DATA_W  input sample.
- ss_tlast  in  1  marks the final sample of the stream.
- ss_tready  out  1  high only in ACCEPT.
- data_EN  out  1  BRAM enable.
- data_WE  out  4  BRAM byte write enables; 4'hF or 0.
- data_A  out  ADDR_W  BRAM byte address = word index × 4.
- data_Di  out  DATA_W  BRAM write data.
- data_Do  in  DATA_W  BRAM read data; valid the cycle after the address is issued.
- mac_valid  out  1  mac_data/mac_idx valid.
- mac_data  out  DATA_W  sample x[n−mac_idx].
- mac_idx  out  4  tap index 0..10.
- mac_last  out  1  with mac_idx==10.
- mac_eos  out  1  with mac_last when the sample carried ss_tlast.

## Operation
- States:
  - IDLE
    - ap_start → CLEAR.
    - wptr := 0.
    - clr_cnt := 0.
  - CLEAR
    - Drives data_EN=1, data_WE=4'hF, data_Di=0, data_A=clr_cnt×4.
    - clr_cnt runs 0..10; after clr_cnt==10 → ACCEPT.
  - ACCEPT
    - ss_tready=1.
    - On ss_tvalid, in that same cycle drive data_EN=1, data_WE=4'hF, data_A=wptr×4, data_Di=ss_tdata.
    - This access is also the tap-0 read.
    - Latch ss_tlast into eos_r.
    - rptr := wptr−1 mod 11.
    - tap := 1.
    - Go to READ.
  - READ
    - Drives data_EN=1, data_WE=0, data_A=rptr×4.
    - Each cycle rptr decrements with 0→10 wrap and tap increments.
    - After tap==10 is issued: wptr := wptr+1 mod 11 (10→0), then go to IDLE if eos_r, else to ACCEPT.
- Read-side pipeline:
  - Every issued read (including the ACCEPT write cycle) sets mac_valid on the next cycle.
  - On that cycle: mac_data=data_Do and mac_idx = the registered tap.
  - mac_last is set when the registered tap==10.
  - mac_eos = mac_last & eos_r.
  - ap_done = mac_eos, one cycle.
- Read-after-write: the BRAM latches its address on the same edge the write lands, so tap 0 returns the new sample.
- The MAC consumer always accepts; there is no backpressure on mac_*.
- ss_tdata is ignored when ss_tready=0.
- ap_start is ignored outside IDLE.
- Outside CLEAR, ACCEPT-handshake and READ cycles: data_EN=0, data_WE=0, data_Di=0, data_A=0.

## Timing
- Reset values: all outputs 0; state IDLE; wptr, rptr, tap, clr_cnt, eos_r all 0.
- Reset asserted mid-run:
  - Next edge returns to IDLE with all outputs 0.
  - Buffer contents are not cleared until the next ap_start.
  - Any in-flight mac_* outputs are dropped.
- ap_start at edge t: CLEAR writes occur on cycles t+1..t+11; ss_tready=1 from t+12.
- Per sample:
  - Handshake cycle c; reads issued c..c+10.
  - mac_valid on c+1..c+11, mac_last at c+11.
  - ss_tready high again at c+11.
  - Throughput is 1 sample per 11 cycles, after 1 idle-free handshake.
- ap_done coincides with mac_last of the tlast sample; state is already IDLE that cycle.

## Structure
- Shared package fir_pkg holds:
  - TAPS = 11
  - the state enum {IDLE, CLEAR, ACCEPT, READ}
  - WORD_SHIFT = 2 for the word→byte address shift.
- One sub-module: fir_wrap_ctr, a mod-TAPS counter with inc/dec/load and a wrap flag. It is instantiated for wptr and rptr; clr_cnt and tap reuse it.

## Test plan
- Reset:
  - Stimulus: hold axis_rst_n=0 for 3 cycles, with ss_tvalid=1 and ap_start=1.
  - Required: every output stays 0 and ss_tready stays 0.
- Clear:
  - Stimulus: ap_start pulse.
  - Required: 11 consecutive writes with data_WE=F, data_Di=0, data_A=0,4,…,40; ss_tready rises on the 12th cycle.
  - Also: a second ap_start pulse during CLEAR has no effect.
- First sample:
  - Stimulus: 5.
  - Required data_A sequence: 0 (write), 40, 36, …, 4.
  - Required mac_data: 5,0,0,…,0 with mac_idx 0..10; mac_last only at idx 10.
- Wrap:
  - Stimulus: samples 1..12.
  - Required: sample 12 is written at data_A=0.
  - Required: its readout is 12,11,…,2 at addresses 0,40,…,4.
- End of stream:
  - Stimulus: 3 samples with ss_tlast on the 3rd.
  - Required: mac_eos and ap_done pulse exactly once, with mac_idx 10 of sample 3.
  - Required: then IDLE, ss_tready=0, and a further ss_tvalid is ignored.
- Reset mid-run:
  - Stimulus: drop axis_rst_n during READ at tap 5.
  - Required: next cycle mac_valid=0 and data_EN=0.
  - Then: a new ap_start re-clears the buffer, and sample 7 reads out 7,0,…,0.
